// File: rtl/bullet_hit_responder_pkg.sv
// Shared types and constants for the bullet hit responder and its collision helpers.
package bullet_hit_responder_pkg;

  localparam int SLOT_COUNT = 8;
  localparam int X_W        = 10;
  localparam int Y_W        = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SCAN  = 2'd2,
    ST_APPLY = 2'd3
  } state_e;

  typedef struct packed {
    logic           active;
    logic           color;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } slot_t;

  // HP after damage, clamped at zero instead of wrapping
  function automatic logic [7:0] sat_sub(input logic [7:0] hp_val, input logic [7:0] dmg);
    logic [7:0] res;
    if (dmg >= hp_val) begin
      res = 8'd0;
    end else begin
      res = hp_val - dmg;
    end
    return res;
  endfunction

endpackage

// File: rtl/bullet_hit_responder_hit_test.sv
// Combinational box test: both unsigned coordinate distances strictly below HIT_RADIUS.
module bullet_hit_responder_hit_test #(
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int HIT_RADIUS = 8
) (
  input  logic [X_W-1:0] bx,
  input  logic [Y_W-1:0] by,
  input  logic [X_W-1:0] px,
  input  logic [Y_W-1:0] py,
  output logic           hit
);

  localparam logic [X_W:0] RAD_X = (X_W+1)'(HIT_RADIUS);
  localparam logic [Y_W:0] RAD_Y = (Y_W+1)'(HIT_RADIUS);

  logic [X_W:0] dx_s;
  logic [Y_W:0] dy_s;

  // Magnitudes are one bit wider than the coordinates so no difference can wrap
  always_comb begin
    if (bx >= px) begin
      dx_s = {1'b0, bx} - {1'b0, px};
    end else begin
      dx_s = {1'b0, px} - {1'b0, bx};
    end
    if (by >= py) begin
      dy_s = {1'b0, by} - {1'b0, py};
    end else begin
      dy_s = {1'b0, py} - {1'b0, by};
    end
    hit = (dx_s < RAD_X) && (dy_s < RAD_Y);
  end

endmodule

// File: rtl/bullet_hit_responder.sv
// Bullet table owner and damage-scan responder: answers collision queries and applies
// the calculator's per-frame damage to player HP.
module bullet_hit_responder
  import bullet_hit_responder_pkg::*;
#(
  parameter int HIT_RADIUS   = 8,
  parameter int MAX_HP       = 200,
  parameter int X_W          = bullet_hit_responder_pkg::X_W,
  parameter int Y_W          = bullet_hit_responder_pkg::Y_W,
  parameter int SCAN_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           frame_tick,
  input  logic [X_W-1:0] player_x,
  input  logic [Y_W-1:0] player_y,
  input  logic           wr_en,
  input  logic [2:0]     wr_idx,
  input  logic [X_W-1:0] wr_x,
  input  logic [Y_W-1:0] wr_y,
  input  logic           wr_active,
  input  logic           wr_color,
  output logic           scan_start,
  input  logic [2:0]     calc_index,
  output logic           collide,
  output logic           color,
  input  logic [7:0]     calc_damage,
  input  logic           calc_complete,
  output logic [7:0]     hp,
  output logic           dead,
  output logic           hp_update,
  input  logic           hp_reload,
  output logic           overrun,
  output logic           scan_error
);

  localparam int CNT_W = $clog2(SCAN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_TIMEOUT - 1);

  slot_t            slot_r [SLOT_COUNT];
  state_e           state_r;
  state_e           state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       dmg_r;
  logic             timeout_s;
  logic [7:0]       hp_r;
  logic [7:0]       hp_new_s;
  logic             dead_r;
  logic             hp_update_r;
  logic             scan_start_r;
  logic             overrun_r;
  logic             scan_error_r;
  logic             hit_s;
  slot_t            sel_s;

  assign sel_s = slot_r[calc_index];

  bullet_hit_responder_hit_test #(
    .X_W        (X_W),
    .Y_W        (Y_W),
    .HIT_RADIUS (HIT_RADIUS)
  ) u_hit_test (
    .bx  (sel_s.x),
    .by  (sel_s.y),
    .px  (player_x),
    .py  (player_y),
    .hit (hit_s)
  );

  assign collide    = sel_s.active & hit_s;
  assign color      = sel_s.color;
  assign scan_start = scan_start_r;
  assign hp         = hp_r;
  assign dead       = dead_r;
  assign hp_update  = hp_update_r;
  assign overrun    = overrun_r;
  assign scan_error = scan_error_r;

  // Slot table: spawner writes are accepted in every FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SLOT_COUNT; i++) begin
        slot_r[i] <= '0;
      end
    end else if (wr_en) begin
      slot_r[wr_idx] <= '{active: wr_active, color: wr_color, x: wr_x, y: wr_y};
    end
  end

  // Next-state decode; the timeout fires on the last permitted SCAN cycle without completion
  always_comb begin
    state_next_s = state_r;
    timeout_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (frame_tick && !dead_r) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: state_next_s = ST_SCAN;
      ST_SCAN: begin
        if (calc_complete) begin
          state_next_s = ST_APPLY;
        end else if (cnt_r == CNT_LAST) begin
          state_next_s = ST_IDLE;
          timeout_s    = 1'b1;
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_APPLY: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register, scan timeout counter and latched damage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      dmg_r        <= 8'd0;
      scan_start_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      scan_start_r <= (state_next_s == ST_START);
      if (state_r == ST_START) begin
        cnt_r <= '0;
      end else if (state_r == ST_SCAN) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (state_r == ST_SCAN && calc_complete) begin
        dmg_r <= calc_damage;
      end
    end
  end

  assign hp_new_s = sat_sub(hp_r, dmg_r);

  // HP update: reload wins over a concurrent APPLY, dead tracks the new value on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_r        <= 8'(MAX_HP);
      dead_r      <= 1'b0;
      hp_update_r <= 1'b0;
    end else if (hp_reload) begin
      hp_r        <= 8'(MAX_HP);
      dead_r      <= 1'b0;
      hp_update_r <= 1'b1;
    end else if (state_r == ST_APPLY) begin
      hp_r        <= hp_new_s;
      dead_r      <= (hp_new_s == 8'd0);
      hp_update_r <= 1'b1;
    end else begin
      hp_update_r <= 1'b0;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r    <= 1'b0;
      scan_error_r <= 1'b0;
    end else begin
      if (frame_tick && state_r != ST_IDLE) begin
        overrun_r <= 1'b1;
      end
      if (timeout_s) begin
        scan_error_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bullet_hit_responder.sv
// Directed self-checking bench for bullet_hit_responder; outputs sampled on the falling edge.
module tb_bullet_hit_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic [9:0] player_x;
  logic [8:0] player_y;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic       wr_active;
  logic       wr_color;
  logic       scan_start;
  logic [2:0] calc_index;
  logic       collide;
  logic       color;
  logic [7:0] calc_damage;
  logic       calc_complete;
  logic [7:0] hp;
  logic       dead;
  logic       hp_update;
  logic       hp_reload;
  logic       overrun;
  logic       scan_error;

  int checks = 0;
  int errors = 0;

  bullet_hit_responder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .player_x      (player_x),
    .player_y      (player_y),
    .wr_en         (wr_en),
    .wr_idx        (wr_idx),
    .wr_x          (wr_x),
    .wr_y          (wr_y),
    .wr_active     (wr_active),
    .wr_color      (wr_color),
    .scan_start    (scan_start),
    .calc_index    (calc_index),
    .collide       (collide),
    .color         (color),
    .calc_damage   (calc_damage),
    .calc_complete (calc_complete),
    .hp            (hp),
    .dead          (dead),
    .hp_update     (hp_update),
    .hp_reload     (hp_reload),
    .overrun       (overrun),
    .scan_error    (scan_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic write_slot(input logic [2:0] idx, input logic [9:0] x, input logic [8:0] y,
                            input logic act, input logic col);
    @(negedge clk);
    wr_en = 1'b1; wr_idx = idx; wr_x = x; wr_y = y; wr_active = act; wr_color = col;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [9:0] px, input logic [8:0] py,
                       input logic [2:0] idx, input logic exp_hit);
    player_x = px; player_y = py; calc_index = idx;
    #1;
    check(tag, collide, exp_hit);
  endtask

  // Full frame: complete arrives gap cycles after scan_start; optional reload alongside APPLY
  task automatic scan_frame(input string tag, input logic [7:0] dmg, input int gap,
                            input logic reload, input logic [7:0] exp_hp, input logic exp_dead);
    int starts;
    starts = 0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check({tag, "_start"}, scan_start, 1'b1);
    starts += int'(scan_start);
    for (int i = 0; i < gap - 1; i++) begin
      @(negedge clk);
      starts += int'(scan_start);
      check({tag, "_noupd"}, hp_update, 1'b0);
    end
    calc_complete = 1'b1;
    calc_damage   = dmg;
    @(negedge clk);
    calc_complete = 1'b0;
    calc_damage   = 8'd0;
    hp_reload     = reload;
    @(negedge clk);
    hp_reload = 1'b0;
    check({tag, "_starts"}, starts, 1);
    check({tag, "_hp"}, hp, exp_hp);
    check({tag, "_dead"}, dead, exp_dead);
    check({tag, "_upd"}, hp_update, 1'b1);
    @(negedge clk);
    check({tag, "_upd_end"}, hp_update, 1'b0);
  endtask

  initial begin
    int starts;
    int upds;
    rst_n = 1'b0; frame_tick = 1'b0; player_x = 10'd0; player_y = 9'd0;
    wr_en = 1'b0; wr_idx = 3'd0; wr_x = 10'd0; wr_y = 9'd0; wr_active = 1'b0; wr_color = 1'b0;
    calc_index = 3'd0; calc_damage = 8'd0; calc_complete = 1'b0; hp_reload = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_hp", hp, 8'd200);
    check("rst_dead", dead, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_scan_error", scan_error, 1'b0);
    check("rst_scan_start", scan_start, 1'b0);
    check("rst_hp_update", hp_update, 1'b0);
    for (int i = 0; i < 8; i++) begin
      probe("rst_collide", 10'd0, 9'd0, 3'(i), 1'b0);
    end

    // Collision table
    write_slot(3'd3, 10'd100, 9'd100, 1'b1, 1'b1);
    probe("hit_slot3", 10'd104, 9'd97, 3'd3, 1'b1);
    check("color_slot3", color, 1'b1);
    probe("miss_slot2", 10'd104, 9'd97, 3'd2, 1'b0);
    probe("edge_dx_pos8", 10'd108, 9'd100, 3'd3, 1'b0);
    probe("edge_dx_neg8", 10'd92, 9'd100, 3'd3, 1'b0);
    probe("edge_dy_pos8", 10'd100, 9'd108, 3'd3, 1'b0);
    probe("near_7_7", 10'd93, 9'd107, 3'd3, 1'b1);
    write_slot(3'd5, 10'd100, 9'd100, 1'b0, 1'b1);
    probe("inactive_slot5", 10'd100, 9'd100, 3'd5, 1'b0);
    check("inactive_color", color, 1'b1);
    write_slot(3'd6, 10'd1020, 9'd0, 1'b1, 1'b0);
    probe("far_no_wrap", 10'd2, 9'd0, 3'd6, 1'b0);
    probe("hi_edge_hit", 10'd1023, 9'd7, 3'd6, 1'b1);

    // Scans and HP
    scan_frame("scan50", 8'd50, 9, 1'b0, 8'd150, 1'b0);
    scan_frame("scan120", 8'd120, 4, 1'b0, 8'd30, 1'b0);
    scan_frame("scan100", 8'd100, 3, 1'b0, 8'd0, 1'b1);

    // Dead: frame_tick ignored without overrun
    starts = 0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      starts += int'(scan_start);
      @(negedge clk);
    end
    check("dead_no_start", starts, 0);
    check("dead_no_overrun", overrun, 1'b0);
    hp_reload = 1'b1;
    @(negedge clk); hp_reload = 1'b0;
    check("reload_hp", hp, 8'd200);
    check("reload_dead", dead, 1'b0);
    check("reload_upd", hp_update, 1'b1);

    // calc_complete in IDLE is ignored
    upds = 0;
    calc_complete = 1'b1; calc_damage = 8'd50;
    @(negedge clk); calc_complete = 1'b0; calc_damage = 8'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      upds += int'(hp_update);
    end
    check("idle_complete_upds", upds, 0);
    check("idle_complete_hp", hp, 8'd200);

    // Timeout
    upds = 0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    check("to_start", scan_start, 1'b1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      upds += int'(hp_update);
    end
    check("to_not_yet", scan_error, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      upds += int'(hp_update);
    end
    check("to_scan_error", scan_error, 1'b1);
    check("to_hp", hp, 8'd200);
    check("to_upds", upds, 0);
    check("to_overrun", overrun, 1'b0);
    scan_frame("after_to", 8'd0, 3, 1'b0, 8'd200, 1'b0);

    // Overrun during SCAN plus reload colliding with APPLY
    starts = 0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    starts += int'(scan_start);
    @(negedge clk); frame_tick = 1'b1;
    starts += int'(scan_start);
    @(negedge clk); frame_tick = 1'b0;
    starts += int'(scan_start);
    @(negedge clk);
    starts += int'(scan_start);
    calc_complete = 1'b1; calc_damage = 8'd10;
    @(negedge clk);
    calc_complete = 1'b0; calc_damage = 8'd0; hp_reload = 1'b1;
    @(negedge clk);
    hp_reload = 1'b0;
    check("ovr_flag", overrun, 1'b1);
    check("ovr_starts", starts, 1);
    check("ovr_reload_hp", hp, 8'd200);
    check("ovr_reload_upd", hp_update, 1'b1);
    @(negedge clk);
    check("ovr_hp_hold", hp, 8'd200);
    check("sticky_scan_error", scan_error, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
